dp_axil_reg_slave: RTL and testbench

//  AXI4-Lite responder holding the Data Plane control/status register bank.

---
 rtl/dp_axil_reg_slave.sv | 135 +++++++++++++
 tb/tb_dp_axil_reg_slave.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_axil_reg_slave.sv
// dp_axil_reg_slave: AXI4-Lite subordinate holding the Data Plane register bank, exported as a flat image.
// Define DP_AXIL_WSTRB_EN for per-byte write strobes; otherwise every write updates the full word.
module dp_axil_reg_slave #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
    localparam int IW = $clog2(NUM_REGS);
    localparam int XW = ADDR_WIDTH - 2;
    localparam logic [XW-1:0] L_NUM = XW'(NUM_REGS);

    typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_VALID} r_state_t;

    w_state_t              r_wstate, w_wnext;
    r_state_t              r_rstate, w_rnext;
    logic                  r_live;
    logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
    logic [XW-1:0]         r_widx;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_bresp;
    logic [1:0]            r_rresp;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_wok, w_rok;
    logic [XW-1:0]         w_idx, w_ridx;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_unused_lsb;

    // Readies stay low until the first edge after reset release.
    assign awready = r_live && (r_wstate == W_IDLE || r_wstate == W_HAVE_W);
    assign wready  = r_live && (r_wstate == W_IDLE || r_wstate == W_HAVE_AW);
    assign arready = r_live && r_rstate == R_IDLE;
    assign bvalid  = r_wstate == W_RESP;
    assign rvalid  = r_rstate == R_VALID;
    assign bresp   = r_bresp;
    assign rresp   = r_rresp;
    assign rdata   = r_rdata;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;
    assign w_idx    = w_aw_hs ? awaddr[ADDR_WIDTH-1:2] : r_widx;
    assign w_data   = w_w_hs ? wdata : r_wdata;
    assign w_wok    = w_idx < L_NUM;
    assign w_ridx   = araddr[ADDR_WIDTH-1:2];
    assign w_rok    = w_ridx < L_NUM;
    assign w_commit = w_wnext == W_RESP && r_wstate != W_RESP;
    assign w_unused_lsb = ^{awaddr[1:0], araddr[1:0]};

`ifdef DP_AXIL_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [DATA_WIDTH/8-1:0] w_strb;
    assign w_strb = w_w_hs ? wstrb : r_wstrb;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) r_wstrb <= '0;
        else if (w_w_hs) r_wstrb <= wstrb;
`else
    logic w_unused_strb;
    assign w_unused_strb = ^wstrb;
`endif

    always_comb begin
        w_wnext = r_wstate;
        if (r_wstate == W_RESP) w_wnext = bready ? W_IDLE : W_RESP;
        else if ((w_aw_hs || r_wstate == W_HAVE_AW) && (w_w_hs || r_wstate == W_HAVE_W)) w_wnext = W_RESP;
        else if (w_aw_hs) w_wnext = W_HAVE_AW;
        else if (w_w_hs) w_wnext = W_HAVE_W;
    end

    always_comb w_rnext = (r_rstate == R_IDLE) ? (w_ar_hs ? R_VALID : R_IDLE) : (rready ? R_IDLE : R_VALID);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
            r_live   <= 1'b0;
            r_widx   <= '0;
            r_wdata  <= '0;
            r_bresp  <= 2'b00;
            r_rresp  <= 2'b00;
            r_rdata  <= '0;
        end else begin
            r_live   <= 1'b1;
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
            if (w_aw_hs) r_widx <= awaddr[ADDR_WIDTH-1:2];
            if (w_w_hs) r_wdata <= wdata;
            if (w_commit) r_bresp <= w_wok ? 2'b00 : 2'b10;
            if (w_ar_hs) begin
                r_rdata <= w_rok ? r_regs[w_ridx[IW-1:0]] : '0;
                r_rresp <= w_rok ? 2'b00 : 2'b10;
            end
        end
    end

    // A read captured on the commit edge sees the pre-write value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_commit && w_wok) begin
`ifdef DP_AXIL_WSTRB_EN
            for (int k = 0; k < DATA_WIDTH/8; k++)
                if (w_strb[k]) r_regs[w_idx[IW-1:0]][8*k +: 8] <= w_data[8*k +: 8];
`else
            r_regs[w_idx[IW-1:0]] <= w_data;
`endif
        end
    end

    genvar i;
    for (i = 0; i < NUM_REGS; i++) begin : g_img
        assign regs_o[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[i];
    end
endmodule

// File: tb/tb_dp_axil_reg_slave.sv
// tb_dp_axil_reg_slave: table vectors, directed corner sequences and random traffic
// checked against an array model of the register bank.
module tb_dp_axil_reg_slave;
    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [11:0]  awaddr = '0, araddr = '0;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         awready, wready, bvalid, arready, rvalid;
    logic [1:0]   bresp, rresp;
    logic [31:0]  rdata;
    logic [511:0] regs_o;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] m [16];

`ifdef DP_AXIL_WSTRB_EN
    localparam logic [31:0] E5 = 32'h11BB33DD;
    localparam logic [31:0] EZ = 32'h11BB33DD;
`else
    localparam logic [31:0] E5 = 32'hAABBCCDD;
    localparam logic [31:0] EZ = 32'hFFFFFFFF;
`endif

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rd;
    } vec_t;
    vec_t tv [12];

    dp_axil_reg_slave dut (
        .clk(clk), .reset_n(reset_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .regs_o(regs_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h, expected %h", n, a, e);
    endtask

    task automatic chkb(input string n, input logic a, input logic e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %b, expected %b", n, a, e);
    endtask

    task automatic chk_img(input string n);
        logic [511:0] e;
        for (int i = 0; i < 16; i++) e[i*32 +: 32] = m[i];
        n_total++;
        if (regs_o === e) n_pass++;
        else $display("FAIL %s: regs_o=%h expected %h", n, regs_o, e);
    endtask

    function automatic void mwrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a[11:2]);
        if (idx < 16) begin
`ifdef DP_AXIL_WSTRB_EN
            for (int k = 0; k < 4; k++) if (s[k]) m[idx][8*k +: 8] = d[8*k +: 8];
`else
            m[idx] = d;
`endif
        end
    endfunction

    function automatic logic [1:0] mresp(input logic [11:0] a);
        return (int'(a[11:2]) < 16) ? 2'b00 : 2'b10;
    endfunction

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int daw, input int dw, input int dbr, output logic [1:0] resp);
        bit got_aw = 0, got_w = 0, ra, rw;
        for (int t = 0; t < 30 && !(got_aw && got_w); t++) begin
            awvalid = !got_aw && t >= daw; awaddr = a;
            wvalid = !got_w && t >= dw; wdata = d; wstrb = s;
            ra = awvalid && awready;
            rw = wvalid && wready;
            @(posedge clk); #1;
            if (ra) got_aw = 1;
            if (rw) got_w = 1;
        end
        awvalid = 0; wvalid = 0;
        chkb("wr_handshake", got_aw && got_w, 1'b1);
        chkb("bvalid_latency", bvalid, 1'b1);
        resp = bresp;
        repeat (dbr) begin
            @(posedge clk); #1;
            chkb("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", 32'(bresp), 32'(resp));
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        chkb("bvalid_drop", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [11:0] a, input int drr, output logic [31:0] d, output logic [1:0] r);
        bit got = 0;
        for (int t = 0; t < 30 && !got; t++) begin
            arvalid = 1; araddr = a;
            got = arready;
            @(posedge clk); #1;
        end
        arvalid = 0;
        chkb("ar_handshake", got, 1'b1);
        chkb("rvalid_latency", rvalid, 1'b1);
        d = rdata; r = rresp;
        repeat (drr) begin
            @(posedge clk); #1;
            chkb("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, d);
        end
        rready = 1; @(posedge clk); #1; rready = 0;
        chkb("rvalid_drop", rvalid, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) m[i] = '0;
        chkb("rst_awready", awready, 1'b0);
        chkb("rst_arready", arready, 1'b0);
        chkb("rst_bvalid", bvalid, 1'b0);
        chkb("rst_rvalid", rvalid, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_resp", 32'({bresp, rresp}), 32'h0);
        chk_img("rst_image");
        reset_n = 1;
        chkb("rel_awready_before_clk", awready, 1'b0);
        @(posedge clk); #1;
        chkb("rel_awready", awready, 1'b1);
        chkb("rel_wready", wready, 1'b1);
        chkb("rel_arready", arready, 1'b1);
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        tv[0]  = '{1'b1, 12'h000, 32'h11223344, 4'hF, 2'b00, 32'h0};
        tv[1]  = '{1'b1, 12'h000, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
        tv[2]  = '{1'b0, 12'h000, 32'h0,        4'h0, 2'b00, E5};
        tv[3]  = '{1'b1, 12'h040, 32'hDEADBEEF, 4'hF, 2'b10, 32'h0};
        tv[4]  = '{1'b0, 12'h040, 32'h0,        4'h0, 2'b10, 32'h0};
        tv[5]  = '{1'b1, 12'h03F, 32'h12345678, 4'hF, 2'b00, 32'h0};
        tv[6]  = '{1'b0, 12'h03C, 32'h0,        4'h0, 2'b00, 32'h12345678};
        tv[7]  = '{1'b1, 12'h000, 32'hFFFFFFFF, 4'h0, 2'b00, 32'h0};
        tv[8]  = '{1'b0, 12'h002, 32'h0,        4'h0, 2'b00, EZ};
        tv[9]  = '{1'b1, 12'hFFC, 32'h00000001, 4'hF, 2'b10, 32'h0};
        tv[10] = '{1'b0, 12'h004, 32'h0,        4'h0, 2'b00, 32'hA5A51234};
        tv[11] = '{1'b0, 12'h800, 32'h0,        4'h0, 2'b10, 32'h0};

        do_reset();

        // AW and W together
        do_write(12'h004, 32'hA5A51234, 4'hF, 0, 0, 0, r);
        mwrite(12'h004, 32'hA5A51234, 4'hF);
        chk("t1_bresp", 32'(r), 32'h0);
        chk("t1_reg1", regs_o[63:32], 32'hA5A51234);
        chk_img("t1_image");

        // W first, AW three cycles later, then a stalled B channel
        wvalid = 1; wdata = 32'h0BADF00D; wstrb = 4'hF;
        chkb("t2_wready_pre", wready, 1'b1);
        @(posedge clk); #1;
        wvalid = 0;
        repeat (2) begin
            chkb("t2_wready_low", wready, 1'b0);
            chkb("t2_bvalid_low", bvalid, 1'b0);
            @(posedge clk); #1;
        end
        awvalid = 1; awaddr = 12'h008;
        chkb("t2_awready", awready, 1'b1);
        @(posedge clk); #1;
        awvalid = 0;
        mwrite(12'h008, 32'h0BADF00D, 4'hF);
        chkb("t2_bvalid", bvalid, 1'b1);
        chk("t2_reg2", regs_o[95:64], 32'h0BADF00D);
        repeat (5) begin
            @(posedge clk); #1;
            chkb("t2_bvalid_stall", bvalid, 1'b1);
            chk("t2_bresp_stall", 32'(bresp), 32'h0);
            chkb("t2_awready_stall", awready, 1'b0);
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        chkb("t2_bvalid_done", bvalid, 1'b0);
        chkb("t2_awready_back", awready, 1'b1);
        chkb("t2_wready_back", wready, 1'b1);
        chk_img("t2_image");

        // Read back with rready stalled
        do_read(12'h004, 3, d, r);
        chk("t3_rdata", d, 32'hA5A51234);
        chk("t3_rresp", 32'(r), 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (tv[i].wr) begin
                mwrite(tv[i].addr, tv[i].data, tv[i].strb);
                do_write(tv[i].addr, tv[i].data, tv[i].strb, i % 3, (i + 1) % 3, i % 2, r);
                chk($sformatf("tv%0d_bresp", i), 32'(r), 32'(tv[i].resp));
                chk_img($sformatf("tv%0d_image", i));
            end else begin
                do_read(tv[i].addr, i % 3, d, r);
                chk($sformatf("tv%0d_rdata", i), d, tv[i].rd);
                chk($sformatf("tv%0d_rresp", i), 32'(r), 32'(tv[i].resp));
            end
        end

        // Read and write of the same register on one edge
        do_write(12'h00C, 32'hCAFE0001, 4'hF, 0, 0, 0, r);
        mwrite(12'h00C, 32'hCAFE0001, 4'hF);
        awvalid = 1; awaddr = 12'h00C; wvalid = 1; wdata = 32'hBEEF0002; wstrb = 4'hF;
        arvalid = 1; araddr = 12'h00C;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        mwrite(12'h00C, 32'hBEEF0002, 4'hF);
        chkb("col_bvalid", bvalid, 1'b1);
        chkb("col_rvalid", rvalid, 1'b1);
        chk("col_rdata_old", rdata, 32'hCAFE0001);
        chk_img("col_image");
        bready = 1; rready = 1; @(posedge clk); #1; bready = 0; rready = 0;
        chkb("col_done", bvalid || rvalid, 1'b0);

        // Reset while in W_HAVE_AW and R_VALID
        awvalid = 1; awaddr = 12'h010;
        @(posedge clk); #1;
        awvalid = 0;
        arvalid = 1; araddr = 12'h004;
        @(posedge clk); #1;
        arvalid = 0;
        chkb("t6_rvalid_pre", rvalid, 1'b1);
        chkb("t6_wready_pre", wready, 1'b1);
        chkb("t6_awready_pre", awready, 1'b0);
        reset_n = 0; #1;
        for (int i = 0; i < 16; i++) m[i] = '0;
        chkb("t6_bvalid", bvalid, 1'b0);
        chkb("t6_rvalid", rvalid, 1'b0);
        chk_img("t6_image");
        @(posedge clk); #1;
        reset_n = 1;
        @(posedge clk); #1;
        chkb("t6_bvalid_after", bvalid, 1'b0);
        do_write(12'h010, 32'h5A5A5A5A, 4'hF, 0, 1, 1, r);
        mwrite(12'h010, 32'h5A5A5A5A, 4'hF);
        chk("t6_bresp", 32'(r), 32'h0);
        chk_img("t6_fresh_image");

        for (int n = 0; n < 60; n++) begin
            int          idx = int'($urandom_range(0, 19));
            logic [11:0] a = 12'(idx * 4 + int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                logic [31:0] wd = $urandom;
                logic [3:0]  ws = 4'($urandom_range(0, 15));
                mwrite(a, wd, ws);
                do_write(a, wd, ws, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                         int'($urandom_range(0, 3)), r);
                chk($sformatf("rnd%0d_bresp", n), 32'(r), 32'(mresp(a)));
                chk_img($sformatf("rnd%0d_image", n));
            end else begin
                do_read(a, int'($urandom_range(0, 3)), d, r);
                chk($sformatf("rnd%0d_rdata", n), d, (idx < 16) ? m[idx] : 32'h0);
                chk($sformatf("rnd%0d_rresp", n), 32'(r), 32'(mresp(a)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
